// File: rtl/vlog_ident_lexer_if.sv
// Character-in / token-out bus for the Verilog identifier lexer.
// The lexer takes the slave side; the character source / token sink takes master.
interface vlog_ident_lexer_if #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned LINE_W  = 16
);
    logic                   ch_valid;
    logic [7:0]             ch_data;
    logic                   ch_last;
    logic                   ch_ready;
    logic                   tok_valid;
    logic                   tok_ready;
    logic [8*MAX_LEN-1:0]   tok_text;
    logic [LEN_W-1:0]       tok_len;
    logic                   tok_trunc;
    logic [LINE_W-1:0]      tok_line;

    modport slave (
        input  ch_valid, ch_data, ch_last, tok_ready,
        output ch_ready, tok_valid, tok_text, tok_len, tok_trunc, tok_line
    );

    modport master (
        output ch_valid, ch_data, ch_last, tok_ready,
        input  ch_ready, tok_valid, tok_text, tok_len, tok_trunc, tok_line
    );
endinterface

// File: rtl/vlog_ident_lexer.sv
// Streaming Verilog-1995 lexer: one char per accept, emits plain identifiers
// with length, truncation flag and starting line; everything else is skipped.
module vlog_ident_lexer #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned LINE_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    vlog_ident_lexer_if.slave bus
);
    localparam int unsigned TEXT_W = 8 * MAX_LEN;

    localparam logic [7:0] C_NL    = 8'h0A;
    localparam logic [7:0] C_DQ    = 8'h22;
    localparam logic [7:0] C_DOL   = 8'h24;
    localparam logic [7:0] C_TICK  = 8'h27;
    localparam logic [7:0] C_STAR  = 8'h2A;
    localparam logic [7:0] C_SLASH = 8'h2F;
    localparam logic [7:0] C_QUES  = 8'h3F;
    localparam logic [7:0] C_BSL   = 8'h5C;
    localparam logic [7:0] C_UND   = 8'h5F;
    localparam logic [7:0] C_BTICK = 8'h60;

    typedef enum logic [3:0] {
        S_WS, S_IDENT, S_NUM, S_SKIPID, S_SLASH,
        S_LCOMM, S_BCOMM, S_BSTAR, S_STR, S_STRESC
    } state_e;

    function automatic logic is_alpha(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_start(input logic [7:0] c);
        return is_alpha(c) || (c == C_UND);
    endfunction

    function automatic logic is_cont(input logic [7:0] c);
        return is_start(c) || is_digit(c) || (c == C_DOL);
    endfunction

    function automatic logic is_numc(input logic [7:0] c);
        return is_alpha(c) || is_digit(c) || (c == C_UND) || (c == C_TICK) || (c == C_QUES);
    endfunction

    state_e              state_q, state_d;
    logic [TEXT_W-1:0]   buf_q, buf_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                trunc_q, trunc_d;
    logic [LINE_W-1:0]   start_line_q, start_line_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                tok_valid_q, tok_valid_d;
    logic [TEXT_W-1:0]   tok_text_q, tok_text_d;
    logic [LEN_W-1:0]    tok_len_q, tok_len_d;
    logic                tok_trunc_q, tok_trunc_d;
    logic [LINE_W-1:0]   tok_line_q, tok_line_d;

    logic                ch_ready_c;
    logic                accept;
    logic [7:0]          ch;
    logic                dispatch;
    logic                emit;

    // A char may only be taken when any pending token is leaving or absent,
    // so an emitting char never overwrites an undelivered token.
    assign ch_ready_c = ~tok_valid_q | bus.tok_ready;
    assign accept     = bus.ch_valid & ch_ready_c;
    assign ch         = bus.ch_data;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        len_d        = len_q;
        trunc_d      = trunc_q;
        start_line_d = start_line_q;
        line_d       = line_q;
        tok_valid_d  = tok_valid_q;
        tok_text_d   = tok_text_q;
        tok_len_d    = tok_len_q;
        tok_trunc_d  = tok_trunc_q;
        tok_line_d   = tok_line_q;
        dispatch     = 1'b0;
        emit         = 1'b0;

        if (tok_valid_q && bus.tok_ready) begin
            tok_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                S_WS: dispatch = 1'b1;
                S_IDENT: begin
                    if (is_cont(ch)) begin
                        if (len_q < LEN_W'(MAX_LEN)) begin
                            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                                if (len_q == LEN_W'(i)) buf_d[8*i +: 8] = ch;
                            end
                            len_d = len_q + LEN_W'(1);
                        end else begin
                            trunc_d = 1'b1;
                        end
                    end else begin
                        emit     = 1'b1;
                        dispatch = 1'b1;
                    end
                end
                S_NUM:    if (!is_numc(ch)) dispatch = 1'b1;
                S_SKIPID: if (!is_cont(ch)) dispatch = 1'b1;
                S_SLASH: begin
                    if (ch == C_SLASH)     state_d = S_LCOMM;
                    else if (ch == C_STAR) state_d = S_BCOMM;
                    else                   dispatch = 1'b1;
                end
                S_LCOMM: if (ch == C_NL) state_d = S_WS;
                S_BCOMM: if (ch == C_STAR) state_d = S_BSTAR;
                S_BSTAR: begin
                    if (ch == C_SLASH)      state_d = S_WS;
                    else if (ch != C_STAR)  state_d = S_BCOMM;
                end
                S_STR: begin
                    if ((ch == C_DQ) || (ch == C_NL)) state_d = S_WS;
                    else if (ch == C_BSL)             state_d = S_STRESC;
                end
                S_STRESC: state_d = S_STR;
                default:  state_d = S_WS;
            endcase

            // Shared "handle as whitespace" entry used by every state that ends a lexeme.
            if (dispatch) begin
                if (is_start(ch)) begin
                    state_d      = S_IDENT;
                    buf_d        = '0;
                    buf_d[7:0]   = ch;
                    len_d        = LEN_W'(1);
                    trunc_d      = 1'b0;
                    start_line_d = line_q;
                end else if (is_digit(ch)) begin
                    state_d = S_NUM;
                end else if ((ch == C_BTICK) || (ch == C_DOL)) begin
                    state_d = S_SKIPID;
                end else if (ch == C_SLASH) begin
                    state_d = S_SLASH;
                end else if (ch == C_DQ) begin
                    state_d = S_STR;
                end else begin
                    state_d = S_WS;
                end
            end

            if ((ch == C_NL) && (line_q != {LINE_W{1'b1}})) begin
                line_d = line_q + LINE_W'(1);
            end

            if (bus.ch_last) begin
                if (state_d == S_IDENT) emit = 1'b1;
                state_d = S_WS;
                line_d  = LINE_W'(1);
            end

            if (emit) begin
                tok_valid_d = 1'b1;
                tok_text_d  = buf_d;
                tok_len_d   = len_d;
                tok_trunc_d = trunc_d;
                tok_line_d  = start_line_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_WS;
            buf_q        <= '0;
            len_q        <= '0;
            trunc_q      <= 1'b0;
            start_line_q <= LINE_W'(1);
            line_q       <= LINE_W'(1);
            tok_valid_q  <= 1'b0;
            tok_text_q   <= '0;
            tok_len_q    <= '0;
            tok_trunc_q  <= 1'b0;
            tok_line_q   <= LINE_W'(1);
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            len_q        <= len_d;
            trunc_q      <= trunc_d;
            start_line_q <= start_line_d;
            line_q       <= line_d;
            tok_valid_q  <= tok_valid_d;
            tok_text_q   <= tok_text_d;
            tok_len_q    <= tok_len_d;
            tok_trunc_q  <= tok_trunc_d;
            tok_line_q   <= tok_line_d;
        end
    end

    assign bus.ch_ready  = ch_ready_c;
    assign bus.tok_valid = tok_valid_q;
    assign bus.tok_text  = tok_text_q;
    assign bus.tok_len   = tok_len_q;
    assign bus.tok_trunc = tok_trunc_q;
    assign bus.tok_line  = tok_line_q;
endmodule

// File: tb/tb_vlog_ident_lexer.sv
// Bench for vlog_ident_lexer: directed source snippets plus random source text,
// with expected tokens from a string-scanning reference model.
module tb_vlog_ident_lexer;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned LINE_W  = 16;

    typedef struct {
        logic [127:0] text;
        int           len;
        bit           trunc;
        int           line;
    } tok_t;
    typedef tok_t tok_q_t[$];

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    vlog_ident_lexer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .LINE_W(LINE_W)) b ();

    vlog_ident_lexer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .LINE_W(LINE_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_start(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) || (c >= 8'h41 && c <= 8'h5A) || c == 8'h5F;
    endfunction
    function automatic bit is_digit(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction
    function automatic bit is_cont(input logic [7:0] c);
        return is_start(c) || is_digit(c) || c == 8'h24;
    endfunction
    function automatic bit is_numc(input logic [7:0] c);
        return is_start(c) || is_digit(c) || c == 8'h27 || c == 8'h3F;
    endfunction

    function automatic logic [127:0] pack(input string t);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < t.len() && k < 16; k++) r[k*8 +: 8] = t[k];
        return r;
    endfunction

    function automatic tok_t mk(input string t, input int line);
        tok_t r;
        r.text  = pack(t);
        r.len   = (t.len() > 16) ? 16 : t.len();
        r.trunc = (t.len() > 16);
        r.line  = line;
        return r;
    endfunction

    // Reference: scan the whole file, skipping each lexeme kind as a unit.
    function automatic tok_q_t model(input string s);
        tok_q_t q;
        int i, j, n, line;
        bit done;
        logic [7:0] c;
        n = s.len(); i = 0; line = 1;
        while (i < n) begin
            c = s[i];
            if (is_start(c)) begin
                j = i;
                while (j < n && is_cont(s[j])) j++;
                q.push_back(mk(s.substr(i, j - 1), line));
                i = j;
            end else if (is_digit(c)) begin
                i++;
                while (i < n && is_numc(s[i])) i++;
            end else if (c == 8'h60 || c == 8'h24) begin
                i++;
                while (i < n && is_cont(s[i])) i++;
            end else if (c == 8'h2F && i + 1 < n && s[i+1] == 8'h2F) begin
                i += 2;
                while (i < n && s[i] != 8'h0A) i++;
            end else if (c == 8'h2F && i + 1 < n && s[i+1] == 8'h2A) begin
                i += 2;
                while (i < n && !(s[i] == 8'h2A && i + 1 < n && s[i+1] == 8'h2F)) begin
                    if (s[i] == 8'h0A) line++;
                    i++;
                end
                i += 2;
            end else if (c == 8'h22) begin
                i++; done = 0;
                while (i < n && !done) begin
                    c = s[i]; i++;
                    if (c == 8'h22) done = 1;
                    else if (c == 8'h5C) begin
                        if (i < n) begin
                            if (s[i] == 8'h0A) line++;
                            i++;
                        end
                    end else if (c == 8'h0A) begin
                        line++; done = 1;
                    end
                end
            end else begin
                if (c == 8'h0A) line++;
                i++;
            end
        end
        return q;
    endfunction

    string start_chars = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ_";
    string cont_chars  = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ_0123456789$";
    string punct_chars = ";()=+/*,.";
    string frags[10] = '{" ", "\n", "8'hFF", "4'b1?0x", "// c x\n", "/* y\n z **/",
                          "\"s\\\"q\\\n t\"", "$display", "`define", "\t"};

    function automatic string gen_src();
        string s;
        int n, l, k;
        s = "";
        n = $urandom_range(6, 20);
        for (int f = 0; f < n; f++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    l = $urandom_range(1, 20);
                    k = $urandom_range(0, start_chars.len() - 1);
                    s = {s, start_chars.substr(k, k)};
                    for (int m = 1; m < l; m++) begin
                        k = $urandom_range(0, cont_chars.len() - 1);
                        s = {s, cont_chars.substr(k, k)};
                    end
                end
                2: begin
                    k = $urandom_range(0, punct_chars.len() - 1);
                    s = {s, punct_chars.substr(k, k)};
                end
                default: s = {s, frags[$urandom_range(0, 9)]};
            endcase
        end
        return s;
    endfunction

    // Feed one source string and collect tokens against the expected queue.
    task automatic run_file(input string s, input bit last, input tok_q_t exp,
                            input int rdy_pct, input int vld_pct);
        int idx, cyc, extra;
        tok_t e;
        idx = 0; cyc = 0; extra = 0;
        while ((idx < s.len() || exp.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            b.tok_ready = ($urandom_range(0, 99) < rdy_pct);
            if (idx < s.len() && $urandom_range(0, 99) < vld_pct) begin
                b.ch_valid = 1'b1;
                b.ch_data  = s[idx];
                b.ch_last  = last && (idx == s.len() - 1);
            end else begin
                b.ch_valid = 1'b0;
                b.ch_data  = 8'($urandom);
                b.ch_last  = 1'($urandom);
            end
            #1;
            if (b.ch_valid && b.ch_ready) idx++;
            if (b.tok_valid && b.tok_ready) begin
                if (exp.size() == 0) extra++;
                else begin
                    e = exp.pop_front();
                    check("tok_text",  b.tok_text,          e.text);
                    check("tok_len",   128'(b.tok_len),     128'(e.len));
                    check("tok_trunc", 128'(b.tok_trunc),   128'(e.trunc));
                    check("tok_line",  128'(b.tok_line),    128'(e.line));
                end
            end
        end
        for (int d = 0; d < 10; d++) begin
            @(negedge clk);
            b.ch_valid  = 1'b0;
            b.ch_last   = 1'b0;
            b.tok_ready = 1'b1;
            #1;
            if (b.tok_valid && last) extra++;
        end
        check("chars_fed", 128'(idx), 128'(s.len()));
        check("tok_missing", 128'(exp.size()), 128'(0));
        check("tok_extra", 128'(extra), 128'(0));
    endtask

    tok_q_t e;
    tok_q_t none;
    string  pre;

    initial begin
        n_checks = 0; n_errors = 0;
        reset_n = 1'b0;
        b.ch_valid = 1'b0; b.ch_data = 8'h00; b.ch_last = 1'b0; b.tok_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tok_valid", 128'(b.tok_valid), 128'(0));
        check("rst_tok_text",  b.tok_text,        128'(0));
        check("rst_tok_len",   128'(b.tok_len),   128'(0));
        check("rst_tok_trunc", 128'(b.tok_trunc), 128'(0));
        check("rst_tok_line",  128'(b.tok_line),  128'(1));
        check("rst_ch_ready",  128'(b.ch_ready),  128'(1));
        @(negedge clk);
        reset_n = 1'b1;

        e = {}; e.push_back(mk("module", 1)); e.push_back(mk("m", 1));
        run_file("module m;\n", 1, e, 100, 100);

        e = {}; e.push_back(mk("a", 1)); e.push_back(mk("c", 2)); e.push_back(mk("f", 3));
        pre = "a//b\nc /*d\n";
        pre = {pre, "e*/ f"};
        run_file(pre, 1, e, 70, 80);

        e = {}; e.push_back(mk("x", 1)); e.push_back(mk("y", 1)); e.push_back(mk("z", 1));
        run_file("8'hFF x $display `define y \"s t\" z", 1, e, 100, 100);

        e = {}; e.push_back(mk("abcdefghijklmnopqrst", 1));
        run_file("abcdefghijklmnopqrst", 1, e, 100, 100);

        // Back-pressure: hold tok_ready low once "ab" is pending.
        pre = "ab ";
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            b.tok_ready = 1'b0; b.ch_valid = 1'b1; b.ch_data = pre[k]; b.ch_last = 1'b0;
            #1;
            check("stall_pre_ready", 128'(b.ch_ready), 128'(1));
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b.ch_data = "c";
            #1;
            check("stall_valid", 128'(b.tok_valid), 128'(1));
            check("stall_ready", 128'(b.ch_ready),  128'(0));
            check("stall_text",  b.tok_text,        pack("ab"));
            check("stall_len",   128'(b.tok_len),   128'(2));
        end
        e = {}; e.push_back(mk("ab", 1)); e.push_back(mk("cd", 1)); e.push_back(mk("e", 1));
        run_file("cd e", 1, e, 100, 100);

        // Reset in the middle of an identifier discards it.
        run_file("mod", 0, none, 100, 100);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 128'(b.tok_valid), 128'(0));
        check("midrst_len",   128'(b.tok_len),   128'(0));
        check("midrst_line",  128'(b.tok_line),  128'(1));
        @(negedge clk);
        reset_n = 1'b1;
        e = {}; e.push_back(mk("ule", 1)); e.push_back(mk("x", 1));
        run_file("ule x", 1, e, 100, 100);

        for (int r = 0; r < 40; r++) begin
            pre = gen_src();
            run_file(pre, 1, model(pre), $urandom_range(20, 100), $urandom_range(40, 100));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
